load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 64, which is the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req_valid (in, 1) and req_ready (out, 1): the request handshake.
REQ-005 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend.
REQ-008 The block SHALL have ports req_addr (in, 32): byte address, and req_wdata (in, 32): store data right-aligned.
REQ-009 The block SHALL have ports resp_valid (out, 1), resp_rdata (out, 32) and resp_err (out, 1): the response.
REQ-010 The block SHALL have ports mem_read (out, 1), mem_write (out, 1), mem_addr (out, 32), mem_wdata (out, 32) and mem_rdata (in, 32): the word-wide data-memory port.

Function
REQ-011 The FSM SHALL have states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 On the req_valid&&req_ready edge, the block SHALL latch all req_* fields; later req_* changes SHALL have no effect until the next IDLE.
REQ-013 Load path: IDLE->RD->RESP; accept at edge k, resp_valid high in the cycle after edge k+2.
REQ-014 Word store path: IDLE->WR->RESP.
REQ-015 Byte and half store path: IDLE->RD->WR->RESP, as a read-modify-write.
REQ-016 In RD, the block SHALL drive mem_read=1 and mem_addr={addr[31:2],2'b00}, and SHALL capture mem_rdata on the edge leaving RD.
REQ-017 In WR, the block SHALL drive mem_write=1 for exactly one cycle, with the same aligned mem_addr.
REQ-018 Lane select SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-019 For a sub-word store, the block SHALL replace only the selected lane of the captured word with the low bits of wdata; other lanes SHALL be unchanged.
REQ-020 Load result: the selected lane SHALL be extended to 32 bits per req_unsigned; word loads SHALL be passed through.
REQ-021 RESP SHALL last one cycle: resp_valid=1, then the FSM SHALL return to IDLE. There SHALL be no back-pressure on the response.
REQ-022 resp_rdata SHALL be 0 for stores and whenever resp_valid=0.
REQ-023 mem_read, mem_write and mem_wdata SHALL be 0 outside RD and WR respectively; mem_addr SHALL be 0 in IDLE.
REQ-024 Error cases are req_size=11, or addr[31:2] >= MEM_WORDS. In either case the block SHALL go IDLE->RESP, set resp_err=1, perform no memory access and drive resp_rdata=0.
REQ-025 resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-026 While rst_n=0 at an edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 except req_ready, which SHALL be 1 after the edge.
REQ-027 A reset mid-operation SHALL abort the transaction: no mem_write after the reset edge and no resp_valid for the aborted request.

Configuration
REQ-028 When macro LSU_MISALIGN_CHECK_EN is defined, a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be treated as an error per REQ-024.
REQ-029 When LSU_MISALIGN_CHECK_EN is undefined, unused low address bits SHALL be ignored: a half access uses addr[1] only, and a word access is aligned down.

Structure
REQ-030 Package lsu_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and the word-width constant.
REQ-031 Combinational lane extract/extend/merge logic SHALL reside in sub-module lsu_byte_lane; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-032 The bench SHALL cover: memory word 5 = 0x8070F0A1; lb at addr 0x16 -> resp_rdata 0x00000070; lbu at addr 0x17 -> 0x00000080; lb at addr 0x17 -> 0xFFFFFF80.
REQ-033 The bench SHALL cover: sh wdata 0x1234BEEF at addr 0x16 over word 5 = 0x8070F0A1 -> one mem_write of 0xBEEFF0A1 to mem_addr 0x14, with resp_valid 3 cycles after accept.
REQ-034 The bench SHALL cover: sw 0xDEADBEEF at addr 0x20 -> mem_read never asserted, mem_write for 1 cycle, and a later lw at addr 0x20 returns 0xDEADBEEF.
REQ-035 The bench SHALL cover: req_size=11, and separately addr 0x100 with MEM_WORDS=64 -> resp_err=1, with mem_read=mem_write=0 throughout.
REQ-036 The bench SHALL cover: rst_n=0 asserted in RD of a sub-word store -> no mem_write occurs, no resp_valid, and req_ready=1 on the next cycle.
REQ-037 The bench SHALL cover: lh at addr 0x15 -> error with LSU_MISALIGN_CHECK_EN defined; without the macro it returns the lower half, sign-extended.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and word width for the load/store unit
package lsu_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_X = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads and lane merge for stores
// Ports: size_i/addr_i select the lane, uns_i picks zero/sign extension,
//        rdata_i is the memory word, wdata_i right-aligned store data,
//        load_o extended load result, store_o merged word to write back.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_i,
  input  logic              uns_i,
  input  logic [WORD_W-1:0] rdata_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] store_o
);
  logic [4:0]        sh;
  logic [WORD_W-1:0] lowm;
  logic [15:0]       lane;
  // halves use addr[1] only, so addr[0] is ignored for half accesses
  assign sh      = size_i == SIZE_H ? {addr_i[1], 4'b0} : size_i == SIZE_B ? {addr_i, 3'b0} : 5'd0;
  assign lowm    = size_i == SIZE_B ? 32'h0000_00FF : size_i == SIZE_H ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign lane    = 16'(rdata_i >> sh);
  assign load_o  = size_i == SIZE_B ? {{24{~uns_i & lane[7]}}, lane[7:0]}
                 : size_i == SIZE_H ? {{16{~uns_i & lane[15]}}, lane}
                 : rdata_i;
  // a word store degenerates to a full-mask replace, i.e. wdata itself
  assign store_o = (rdata_i & ~(lowm << sh)) | ((wdata_i & lowm) << sh);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store unit over a word-wide synchronous-read memory
// Ports: clk/rst_n (sync active-low reset); req_* request with valid/ready handshake;
//        resp_valid/resp_rdata/resp_err one-cycle response; mem_* word-wide memory port.
// Memory read data is taken one cycle after mem_read is raised, so RD spans two cycles.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  state_e            state_q;
  logic              rd2_q, write_q, uns_q, mis, err;
  logic [1:0]        size_q, addr_q;
  logic [WORD_W-1:0] wdata_q, load_word, store_word;
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (req_size == SIZE_H && req_addr[0]) || (req_size == SIZE_W && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign err = req_size == SIZE_X || {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS) || mis;
  lsu_byte_lane u_lane (
    .size_i (size_q),
    .addr_i (addr_q),
    .uns_i  (uns_q),
    .rdata_i(mem_rdata),
    .wdata_i(wdata_q),
    .load_o (load_word),
    .store_o(store_word)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd2_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          write_q   <= req_write;
          size_q    <= req_size;
          uns_q     <= req_unsigned;
          addr_q    <= req_addr[1:0];
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
          if (err) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (req_write && req_size == SIZE_W) begin
            state_q   <= WR;
            mem_write <= 1'b1;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
          end else begin
            state_q  <= RD;
            mem_read <= 1'b1;
            mem_addr <= {req_addr[31:2], 2'b00};
          end
        end
        RD: begin
          rd2_q <= ~rd2_q;
          if (rd2_q) begin
            mem_read <= 1'b0;
            if (write_q) begin
              state_q   <= WR;
              mem_write <= 1'b1;
              mem_wdata <= store_word;
            end else begin
              state_q    <= RESP;
              mem_addr   <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= load_word;
            end
          end
        end
        WR: begin
          state_q    <= RESP;
          mem_write  <= 1'b0;
          mem_wdata  <= '0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
